// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: opcodes, funct3 access codes, FSM states.
package mem_stage_pkg;

    localparam logic [4:0] OPCODE_LOAD  = 5'b00000;
    localparam logic [4:0] OPCODE_STORE = 5'b01000;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;
    localparam logic [2:0] FUNCT3_SD = 3'b011;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } mem_state_e;

    // Undefined size codes are folded into the misaligned outcome so they never reach the bus.
    function automatic logic access_misaligned(input logic       is_store,
                                               input logic [2:0] funct3,
                                               input logic [2:0] off);
        logic mis;
        if (is_store && (funct3 > FUNCT3_SD)) begin
            mis = 1'b1;
        end else if (!is_store && (funct3 == 3'b111)) begin
            mis = 1'b1;
        end else begin
            case (funct3[1:0])
                2'b00:   mis = 1'b0;
                2'b01:   mis = off[0];
                2'b10:   mis = (off[1:0] != 2'b00);
                default: mis = (off != 3'b000);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane placement for stores and lane extraction plus sign/zero extension for loads.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  wmask_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);

    logic [7:0]  size_mask;
    logic [63:0] shifted;

    // Store lanes: size mask and data shifted up by the byte offset.
    always_comb begin
        unique case (funct3_i[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        wmask_o = size_mask << off_i;
        wdata_o = wdata_i << {off_i, 3'b000};
    end

    // Load lanes: bring the addressed bytes down to bit 0, then extend to 64 bits.
    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            FUNCT3_LB:  rdata_o = {{56{shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:  rdata_o = {{48{shifted[15]}}, shifted[15:0]};
            FUNCT3_LW:  rdata_o = {{32{shifted[31]}}, shifted[31:0]};
            FUNCT3_LBU: rdata_o = {56'd0, shifted[7:0]};
            FUNCT3_LHU: rdata_o = {48'd0, shifted[15:0]};
            FUNCT3_LWU: rdata_o = {32'd0, shifted[31:0]};
            default:    rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one request/grant/response data-memory transaction per mem_start.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_start,
    input  logic [4:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       wdata_i,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [7:0]        dmem_wmask,
    output logic [63:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [63:0]       dmem_rdata,
    output logic              busy,
    output logic              done,
    output logic              rd_wen,
    output logic [63:0]       rd_data,
    output logic              misalign,
    output logic              bus_err
);

    localparam int unsigned     CntW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);

    mem_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [4:0]        op_q, op_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rd_data_q, rd_data_d;
    logic              rd_wen_q, rd_wen_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic              is_store_q;
    logic [7:0]        lane_wmask;
    logic [63:0]       lane_wdata;
    logic [63:0]       lane_rdata;

    assign is_store_q = (op_q == OPCODE_STORE);
    assign cnt_inc    = cnt_q + 1'b1;

    mem_lane_align u_lane (
        .funct3_i (f3_q),
        .off_i    (addr_q[2:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (dmem_rdata),
        .wmask_o  (lane_wmask),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    // Next-state logic; the status flags are only ever set on the edge that enters StDone.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_wen_d   = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_start) begin
                    op_d    = opcode_i;
                    f3_d    = funct3_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = '0;
                    if ((opcode_i != OPCODE_LOAD) && (opcode_i != OPCODE_STORE)) begin
                        state_d = StDone;
                    end else if (access_misaligned(opcode_i == OPCODE_STORE, funct3_i,
                                                   addr_i[2:0])) begin
                        state_d    = StDone;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_inc;
                // A grant in the last allowed cycle still wins over the timeout.
                if (dmem_gnt) begin
                    state_d = is_store_q ? StDone : StWait;
                end else if (cnt_inc == TimeoutCnt) begin
                    state_d   = StDone;
                    bus_err_d = 1'b1;
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (dmem_rvalid) begin
                    state_d   = StDone;
                    rd_wen_d  = 1'b1;
                    rd_data_d = lane_rdata;
                end else if (cnt_inc == TimeoutCnt) begin
                    state_d   = StDone;
                    bus_err_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched-field registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_wen_q   <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_wen_q   <= rd_wen_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Bus fields come straight from the latched instruction, so they stay stable through StReq.
    always_comb begin
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        dmem_req   = (state_q == StReq);
        dmem_we    = is_store_q;
        dmem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
        dmem_wmask = is_store_q ? lane_wmask : 8'h00;
        dmem_wdata = is_store_q ? lane_wdata : 64'd0;
        rd_wen     = rd_wen_q;
        rd_data    = rd_data_q;
        misalign   = misalign_q;
        bus_err    = bus_err_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an access-level reference model.
module tb_mem_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_start;
    logic [4:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [7:0]  dmem_wmask;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        busy;
    logic        done;
    logic        rd_wen;
    logic [63:0] rd_data;
    logic        misalign;
    logic        bus_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model_rd = 64'd0;

    mem_stage #(
        .TIMEOUT_CYCLES (TO),
        .ADDR_W         (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_start   (mem_start),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wmask  (dmem_wmask),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .busy        (busy),
        .done        (done),
        .rd_wen      (rd_wen),
        .rd_data     (rd_data),
        .misalign    (misalign),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access: g = REQ cycle carrying gnt, r = WAIT cycles before rvalid, rdv = read word.
    task automatic run_access(input logic [4:0] op, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wd, input int g, input int r,
                              input logic [63:0] rdv);
        int          bytes, off, exp_cyc, exp_req, n, req_cnt;
        bit          is_ld, is_st, mis, access, err;
        logic [63:0] lowmask, word, exp_ext, exp_wdata;
        logic [15:0] mask16;

        // Reference model
        bytes = 1 << f3[1:0];
        off   = int'(addr[2:0]);
        is_ld = (op == 5'b00000);
        is_st = (op == 5'b01000);
        mis   = 1'b0;
        if (is_st && f3 > 3) mis = 1'b1;
        else if (is_ld && f3 == 3'b111) mis = 1'b1;
        else if ((is_ld || is_st) && (off % bytes != 0)) mis = 1'b1;
        access = (is_ld || is_st) && !mis;
        err    = 1'b0;
        if (!access) begin
            exp_cyc = 1; exp_req = 0;
        end else if (g > TO - 1) begin
            err = 1'b1; exp_cyc = TO + 1; exp_req = TO;
        end else if (is_st) begin
            exp_cyc = g + 2; exp_req = g + 1;
        end else if (g + 1 + r > TO - 1) begin
            err = 1'b1; exp_cyc = TO + 1; exp_req = g + 1;
        end else begin
            exp_cyc = g + r + 3; exp_req = g + 1;
        end
        mask16    = ((16'd1 << bytes) - 16'd1) << off;
        exp_wdata = wd << (8 * off);
        lowmask   = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
        word      = (rdv >> (8 * off)) & lowmask;
        if (bytes < 8 && !f3[2] && word[8 * bytes - 1]) word = word | ~lowmask;
        exp_ext = word;
        if (access && is_ld && !err) model_rd = exp_ext;

        // Stimulus and observation
        mem_start = 1'b1; opcode_i = op; funct3_i = f3; addr_i = addr; wdata_i = wd;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        tick();
        mem_start = 1'b0;
        n = 0; req_cnt = 0;
        while (!done && n < 40) begin
            dmem_gnt    = (n == g) || (n > g && $urandom_range(0, 1) == 1);
            dmem_rvalid = (n == g + 1 + r) || (n <= g && $urandom_range(0, 1) == 1);
            dmem_rdata  = (n == g + 1 + r) ? rdv : {$urandom, $urandom};
            // Stray starts and field changes while busy must be ignored.
            mem_start   = ($urandom_range(0, 3) == 0);
            opcode_i    = 5'($urandom); funct3_i = 3'($urandom);
            addr_i      = {$urandom, $urandom}; wdata_i = {$urandom, $urandom};
            if (dmem_req) req_cnt++;
            if (n == 0 && access) begin
                check_eq("bus_addr", dmem_addr, addr & ~64'h7);
                check_eq("bus_we", 64'(dmem_we), 64'(is_st));
                if (is_st) begin
                    check_eq("bus_wmask", 64'(dmem_wmask), 64'(mask16[7:0]));
                    check_eq("bus_wdata", dmem_wdata, exp_wdata);
                end
            end
            tick();
            n++;
        end
        mem_start = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (!done) begin
            check_eq("done_seen", 64'(done), 64'd1);
        end else begin
            check_eq("latency", 64'(n + 1), 64'(exp_cyc));
            check_eq("req_cycles", 64'(req_cnt), 64'(exp_req));
            check_eq("rd_wen", 64'(rd_wen), 64'(access && is_ld && !err));
            check_eq("misalign", 64'(misalign), 64'(mis));
            check_eq("bus_err", 64'(bus_err), 64'(err));
            check_eq("rd_data", rd_data, model_rd);
        end
        tick();
        check_eq("done_pulse", 64'(done), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int          sel, bytes, g, r;
        logic [4:0]  op;
        logic [2:0]  f3, off;
        logic [63:0] a;

        rst = 1'b1; mem_start = 1'b0; opcode_i = '0; funct3_i = '0; addr_i = '0; wdata_i = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick(); tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_req", 64'(dmem_req), 64'd0);
        check_eq("rst_we", 64'(dmem_we), 64'd0);
        check_eq("rst_wmask", 64'(dmem_wmask), 64'd0);
        check_eq("rst_addr", dmem_addr, 64'd0);
        check_eq("rst_wdata", dmem_wdata, 64'd0);
        check_eq("rst_flags", {61'd0, rd_wen, misalign, bus_err}, 64'd0);
        check_eq("rst_rd_data", rd_data, 64'd0);
        rst = 1'b0;
        tick();

        // Directed cases
        run_access(5'b00000, 3'b000, 64'h8000_0003, 64'd0, 0, 0, 64'h0000_0000_8000_0000);
        check_eq("lb_value", rd_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_access(5'b01000, 3'b001, 64'h8000_0006, 64'h1234, 0, 0, 64'd0);
        run_access(5'b00000, 3'b010, 64'h8000_0002, 64'd0, 0, 0, 64'd0);
        run_access(5'b00000, 3'b110, 64'h8000_0004, 64'd0, 3, 0, 64'h8765_4321_0000_0000);
        check_eq("lwu_value", rd_data, 64'h0000_0000_8765_4321);
        run_access(5'b00000, 3'b011, 64'h8000_0000, 64'd0, 99, 0, 64'd0);
        run_access(5'b00100, 3'b000, 64'h8000_0000, 64'd0, 0, 0, 64'd0);
        run_access(5'b01000, 3'b100, 64'h8000_0000, 64'd5, 0, 0, 64'd0);
        run_access(5'b01000, 3'b011, 64'h8000_0008, 64'hDEAD_BEEF_0123_4567, 2, 0, 64'd0);

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                op = 5'b00000; f3 = 3'($urandom);
            end else if (sel < 9) begin
                op = 5'b01000;
                f3 = ($urandom_range(0, 4) == 4) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            end else begin
                op = 5'($urandom_range(1, 31));
                if (op == 5'b01000) op = 5'b01001;
                f3 = 3'($urandom);
            end
            bytes = 1 << f3[1:0];
            off   = 3'($urandom);
            if ($urandom_range(0, 9) < 7) off = off & ~3'(bytes - 1);
            a = {$urandom, $urandom};
            a[2:0] = off;
            g = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 6);
            r = $urandom_range(0, 3);
            run_access(op, f3, a, {$urandom, $urandom}, g, r, {$urandom, $urandom});
        end

        // Reset while waiting for read data
        mem_start = 1'b1; opcode_i = 5'b00000; funct3_i = 3'b011; addr_i = 64'h8000_0010;
        tick();
        mem_start = 1'b0; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rd = 64'd0;
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_req", 64'(dmem_req), 64'd0);
        for (int k = 0; k < 3; k++) begin
            dmem_rvalid = 1'b1; dmem_rdata = {$urandom, $urandom};
            tick();
            check_eq("rst_mid_done", 64'(done), 64'd0);
        end
        dmem_rvalid = 1'b0;
        check_eq("rst_mid_rd", rd_data, model_rd);
        run_access(5'b00000, 3'b101, 64'h8000_0022, 64'd0, 1, 1, 64'h0000_0000_F00D_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage in the multi-cycle RV64I core.
- Takes the effective address, store data and decoded opcode/funct3 for one instruction.
- Runs a request/grant/response transaction on the data-memory port, aligning byte lanes and sign/zero-extending load results.
- Returns a one-cycle completion pulse plus the writeback value to the instruction-cycle controller.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ plus WAIT before the access is aborted with bus_err.
- ADDR_W, 64: width of the address and data-memory address buses.

Ports:
- clk  in  1  system clock; every state element is updated on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_start  in  1  one-cycle pulse from the cycle controller; latches the instruction fields below.
- opcode_i  in  5  inst[6:2]; LOAD=5'b00000, STORE=5'b01000.
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- addr_i  in  ADDR_W  effective address computed by the execute stage.
- wdata_i  in  64  store data, right-aligned.
- dmem_req  out  1  transaction request; held high until granted.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  address with addr[2:0] forced to zero.
- dmem_wmask  out  8  byte-enable mask.
- dmem_wdata  out  64  store data shifted into its byte lanes.
- dmem_gnt  in  1  request accepted in this cycle.
- dmem_rvalid  in  1  load data valid in this cycle.
- dmem_rdata  in  64  aligned 64-bit read word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- rd_wen  out  1  writeback enable; valid while done is high.
- rd_data  out  64  load result; held until the next mem_start.
- misalign  out  1  address misaligned; valid while done is high.
- bus_err  out  1  access timed out; valid while done is high.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0.
- rst takes priority in any state. If asserted mid-transaction, dmem_req is 0 from the next edge and any later gnt or rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, on mem_start: latch opcode, funct3, addr and wdata, then:
  - opcode is neither LOAD nor STORE: go to DONE with rd_wen=0 (pass-through, no bus access).
  - address misaligned for the size (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0): go to DONE with misalign=1. No bus access and rd_wen=0.
  - otherwise: go to REQ.
- REQ:
  - dmem_req=1; dmem_addr, dmem_we, dmem_wmask and dmem_wdata are stable for the whole state.
  - On gnt: a store goes to DONE; a load goes to WAIT.
- WAIT: dmem_req=0. On rvalid, capture the extended load data and go to DONE.
- Timeout: the counter increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES, go to DONE with bus_err=1 and rd_wen=0.
- DONE: done=1 for exactly one cycle, then IDLE. rd_wen=1 only for a successful load.
- Lane rules, with off = addr[2:0]:
  - Store: wmask = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) << off; wdata = wdata_i << (8*off).
  - Load: shifted = rdata >> (8*off), then sign-extend (B/H/W) or zero-extend (BU/HU/WU). D passes all 64 bits.
- Latency with gnt in the first REQ cycle (start edge = cycle 0):
  - store: done in cycle 2.
  - load with rvalid in cycle 2: done in cycle 3.
- mem_start while busy=1 is ignored; no field is re-latched.
- rvalid outside WAIT is ignored. gnt outside REQ is ignored.
- funct3 values 111 (load) and 1xx (store) are treated as misaligned accesses: misalign=1, no bus access.

Decomposition:
- The shared defines header gets OPCODE_LOAD, OPCODE_STORE, the FUNCT3_LB..LWU and FUNCT3_SB..SD constants, and the state encodings.
- One combinational sub-module, mem_lane_align, holds the wmask/wdata shifting and the load extraction/extension; the FSM stays in mem_stage.

Test Plan:
- LB from addr 0x80000003, rdata 0x00000000_FF000000, gnt immediate, rvalid next cycle -> done in cycle 3; rd_wen=1; rd_data=0xFFFFFFFF_FFFFFF80 only if byte3=0x80, so the bench drives 0x00000000_80000000.
- SH to addr 0x80000006, wdata_i 0x1234 -> dmem_wmask=0xC0, dmem_wdata=0x12340000_00000000, dmem_addr=0x80000000, dmem_we=1; done in cycle 2; rd_wen=0.
- LW from addr 0x80000002 -> no dmem_req; done one cycle after start; misalign=1, rd_wen=0.
- LWU from addr 0x80000004 with gnt withheld 3 cycles and rdata 0x87654321_00000000 -> req held 4 cycles; rd_data=0x00000000_87654321.
- TIMEOUT_CYCLES=8, load with gnt never asserted -> done with bus_err=1 after 8 cycles in REQ; rd_wen=0.
- rst asserted in WAIT, then rvalid pulses -> busy=0 and dmem_req=0 after the edge; no done pulse; rd_data stays 0.
